univ_mod_counter: RTL and testbench
===================================

# univ_mod_counter

Parametrised successor to the universal binary counter. An N-bit up/down counter with run-time programmable lower and upper bounds, a programmable step size, and a selectable wrap or saturate mode. It also gives registered wrap-event and configuration-error indications. It sits where the plain universal counter sits today: timer/prescaler and address-sequencing logic that needs a modulus other than 2^N.

## Interface
Parameters:
- N, 8, counter width in bits (N >= 2)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- syn_clr  in  1  synchronous clear to lo; highest synchronous priority
- load  in  1  synchronous parallel load of d
- en  in  1  count enable
- up  in  1  direction: 1 = count up, 0 = count down
- sat  in  1  mode: 1 = saturate at bound, 0 = wrap to opposite bound
- step  in  N  increment/decrement amount; 0 means hold
- lo  in  N  lower bound (inclusive)
- hi  in  N  upper bound (inclusive)
- d  in  N  load data
- q  out  N  counter value (registered)
- max_tick  out  1  combinational: q == hi and cfg_err == 0
- min_tick  out  1  combinational: q == lo and cfg_err == 0
- wrap  out  1  registered one-cycle pulse: a wrap occurred on the previous edge
- cfg_err  out  1  combinational: hi < lo

## Operation
- Reset: q = 0, wrap = 0. Reset is effective immediately and overrides everything, including mid-count.
- Configuration error:
  - When cfg_err = 1, q holds and wrap = 0 regardless of syn_clr, load or en.
  - Normal operation resumes on the first edge after cfg_err deasserts.
- Synchronous priority, per rising edge (with cfg_err = 0): syn_clr > load > en > hold.
  - syn_clr: q <= lo.
  - load: q <= clamp(d, lo, hi). d < lo gives lo; d > hi gives hi.
  - en = 0, or step = 0: q holds.
- Out-of-range recovery: when en = 1 and q lies outside [lo, hi] (for example after lo/hi changed), the next count edge sets q <= lo if up = 1, or q <= hi if up = 0. No wrap pulse is raised.
- Count up (en = 1, q in range):
  - Compute s = q + step in N+1 bits.
  - If s <= hi: q <= s[N-1:0].
  - Else, with sat = 1: q <= hi.
  - Else, with sat = 0: q <= lo and wrap <= 1.
- Count down (en = 1, q in range):
  - Underflow when q < lo + step, computed in N+1 bits.
  - No underflow: q <= q - step.
  - Underflow with sat = 1: q <= lo.
  - Underflow with sat = 0: q <= hi and wrap <= 1.
- Wrapping always lands exactly on the opposite bound; there is no modular remainder carry.
- In saturate mode, a count attempt while at the bound leaves q unchanged and wrap = 0.
- lo == hi: q is pinned to lo on every count. max_tick = min_tick = 1. With sat = 0, every enabled count with step > 0 pulses wrap.
- wrap is 0 on any edge that is not a wrap event, including syn_clr and load edges.

## Timing
- q, wrap: update on the rising clk edge. Latency from inputs sampled at edge k to q valid after edge k is 1 cycle.
- max_tick, min_tick, cfg_err: combinational from q, lo, hi; no added latency.
- wrap: asserted for exactly one cycle, following the edge on which the wrap happened. Back-to-back wraps give consecutive high cycles.
- All control inputs (syn_clr, load, en, up, sat, step, lo, hi, d) are sampled only at rising edges. The bench drives them on the falling edge.
- Reset asserted asynchronously mid-cycle forces q = 0 and wrap = 0 before the next edge. Deassertion is synchronised by the user.

## Test plan
Use N = 4, lo = 3, hi = 12 unless stated.

1. Reset and load/clear:
   - Stimulus: reset pulse, then load with d = 7, then syn_clr asserted together with load and d = 9.
   - Required response: q = 0 after reset; q = 7 after the load; q = 3 after the syn_clr edge (syn_clr wins); wrap = 0 throughout.
2. Up, wrap mode:
   - Stimulus: step = 4, sat = 0, up = 1, start from q = 3.
   - Required response: q sequence 3, 7, 11, 3. wrap is high for the single cycle after the 11 -> 3 edge. max_tick never asserts.
3. Down, saturate mode:
   - Stimulus: step = 5, sat = 1, up = 0, start from q = 12.
   - Required response: q sequence 12, 7, 3, 3. min_tick = 1 from the first 3 onward. wrap = 0.
4. Load clamp and out-of-range recovery:
   - Stimulus A: load d = 15.
   - Stimulus B: change lo = 8 while q = 5, then one up count with step = 1.
   - Required response: A gives q = 12. B gives q = 8 with no wrap pulse.
5. Config error and degenerate range:
   - Stimulus: set lo = 10, hi = 6 with en = 1, then restore hi = 12; separately set lo = hi = 9 with sat = 0 and step = 1.
   - Required response: with hi < lo, cfg_err = 1 and q frozen over 4 edges; counting resumes on the edge after hi is restored. With lo = hi = 9, q = 9, max_tick = min_tick = 1, and wrap is high every cycle.
6. Async reset mid-operation:
   - Stimulus: assert reset between edges while counting at q = 11 with a wrap pending.
   - Required response: q = 0 and wrap = 0 immediately, with no wrap pulse afterwards.

Source files
------------

// File: rtl/univ_mod_counter.sv
// univ_mod_counter
// N-bit up/down counter with run-time programmable inclusive bounds [lo, hi],
// programmable step, and wrap or saturate behaviour at the bounds.
// q and wrap are registered; max_tick, min_tick and cfg_err are decoded
// combinationally from the current count and bounds.

module univ_mod_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         syn_clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic         sat,
    input  logic [N-1:0] step,
    input  logic [N-1:0] lo,
    input  logic [N-1:0] hi,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic         max_tick,
    output logic         min_tick,
    output logic         wrap,
    output logic         cfg_err
);

    // One decoded action per edge; the datapath below only has to honour it.
    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_CLR     = 3'd1,
        OP_LOAD    = 3'd2,
        OP_RECOVER = 3'd3,
        OP_STEP    = 3'd4,
        OP_SAT     = 3'd5,
        OP_WRAP    = 3'd6
    } op_e;

    // Limit a value to the inclusive range [lo_v, hi_v].
    function automatic logic [N-1:0] clamp_fn(
        input logic [N-1:0] v,
        input logic [N-1:0] lo_v,
        input logic [N-1:0] hi_v
    );
        logic [N-1:0] r;
        if (v < lo_v) begin
            r = lo_v;
        end else if (v > hi_v) begin
            r = hi_v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [N-1:0] q_r;
    logic         wrap_r;
    logic [N-1:0] q_next_s;
    logic         wrap_next_s;

    logic         cfg_err_s;
    logic         in_range_s;
    logic         step_zero_s;
    logic [N:0]   sum_s;
    logic [N:0]   lo_plus_step_s;
    logic [N-1:0] diff_s;
    logic         up_ovf_s;
    logic         dn_unf_s;
    op_e          op_s;

    // Bound checks and arithmetic; the extra bit keeps carries from aliasing.
    assign cfg_err_s      = (hi < lo);
    assign in_range_s     = (q_r >= lo) && (q_r <= hi);
    assign step_zero_s    = (step == {N{1'b0}});
    assign sum_s          = {1'b0, q_r} + {1'b0, step};
    assign lo_plus_step_s = {1'b0, lo} + {1'b0, step};
    assign diff_s         = q_r - step;
    assign up_ovf_s       = (sum_s > {1'b0, hi});
    assign dn_unf_s       = ({1'b0, q_r} < lo_plus_step_s);

    // Resolve the control priority into a single action for the coming edge.
    always_comb begin
        op_s = OP_HOLD;
        if (cfg_err_s) begin
            op_s = OP_HOLD;
        end else if (syn_clr) begin
            op_s = OP_CLR;
        end else if (load) begin
            op_s = OP_LOAD;
        end else if (!en || step_zero_s) begin
            op_s = OP_HOLD;
        end else if (!in_range_s) begin
            op_s = OP_RECOVER;
        end else if (up ? up_ovf_s : dn_unf_s) begin
            op_s = sat ? OP_SAT : OP_WRAP;
        end else begin
            op_s = OP_STEP;
        end
    end

    // Next count and wrap flag for the decoded action.
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        case (op_s)
            OP_HOLD: begin
                q_next_s = q_r;
            end
            OP_CLR: begin
                q_next_s = lo;
            end
            OP_LOAD: begin
                q_next_s = clamp_fn(d, lo, hi);
            end
            OP_RECOVER: begin
                // Re-enter the range at the bound the direction starts from.
                q_next_s = up ? lo : hi;
            end
            OP_STEP: begin
                q_next_s = up ? sum_s[N-1:0] : diff_s;
            end
            OP_SAT: begin
                q_next_s = up ? hi : lo;
            end
            OP_WRAP: begin
                // Land exactly on the opposite bound, no remainder carried.
                q_next_s    = up ? lo : hi;
                wrap_next_s = 1'b1;
            end
            default: begin
                q_next_s    = q_r;
                wrap_next_s = 1'b0;
            end
        endcase
    end

    // Count and wrap-pulse registers; reset acts immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_r    <= {N{1'b0}};
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    assign q        = q_r;
    assign wrap     = wrap_r;
    assign cfg_err  = cfg_err_s;
    assign max_tick = (q_r == hi) && !cfg_err_s;
    assign min_tick = (q_r == lo) && !cfg_err_s;

endmodule

// File: tb/tb_univ_mod_counter.sv
// Scoreboard bench for univ_mod_counter (N = 4): each driven cycle pushes the
// expected post-edge state from an integer reference model; a monitor pops
// and compares shortly after each rising edge. Directed checks follow the
// scenarios of interest, then randomized traffic.

module tb_univ_mod_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         syn_clr = 1'b0;
    logic         load = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b1;
    logic         sat = 1'b0;
    logic [N-1:0] step = 4'd0;
    logic [N-1:0] lo = 4'd3;
    logic [N-1:0] hi = 4'd12;
    logic [N-1:0] d = 4'd0;
    logic [N-1:0] q;
    logic         max_tick;
    logic         min_tick;
    logic         wrap;
    logic         cfg_err;

    univ_mod_counter #(.N(N)) dut (
        .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
        .up(up), .sat(sat), .step(step), .lo(lo), .hi(hi), .d(d),
        .q(q), .max_tick(max_tick), .min_tick(min_tick), .wrap(wrap),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit wrap;
        bit mx;
        bit mn;
        bit ce;
    } exp_t;

    exp_t sb_q[$];
    int   nerr = 0;
    int   nchk = 0;
    int   m_q  = 0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: apply the counter rules to the current inputs in plain
    // integer arithmetic and queue the state expected after the next edge.
    task automatic predict();
        int l, h, s, nq;
        bit w;
        exp_t e;
        l  = lo;
        h  = hi;
        s  = step;
        nq = m_q;
        w  = 1'b0;
        if (h < l) begin
            nq = m_q;
        end else if (syn_clr) begin
            nq = l;
        end else if (load) begin
            nq = (int'(d) < l) ? l : ((int'(d) > h) ? h : int'(d));
        end else if (en && s != 0) begin
            if (m_q < l || m_q > h) begin
                nq = up ? l : h;
            end else if (up) begin
                if (m_q + s <= h) nq = m_q + s;
                else if (sat)     nq = h;
                else begin nq = l; w = 1'b1; end
            end else begin
                if (m_q - s >= l) nq = m_q - s;
                else if (sat)     nq = l;
                else begin nq = h; w = 1'b1; end
            end
        end
        m_q    = nq;
        e.q    = nq;
        e.wrap = w;
        e.mx   = (nq == h) && !(h < l);
        e.mn   = (nq == l) && !(h < l);
        e.ce   = (h < l);
        sb_q.push_back(e);
    endtask

    // Predict then advance to the next falling edge, n times.
    task automatic go(input int n);
        repeat (n) begin
            predict();
            @(negedge clk);
        end
    endtask

    // Monitor: compare every presented output against the queued expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_q",        int'(q),        e.q);
            check("sb_wrap",     int'(wrap),     int'(e.wrap));
            check("sb_max_tick", int'(max_tick), int'(e.mx));
            check("sb_min_tick", int'(min_tick), int'(e.mn));
            check("sb_cfg_err",  int'(cfg_err),  int'(e.ce));
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        check("reset_q", int'(q), 0);
        check("reset_wrap", int'(wrap), 0);
        reset = 1'b0;
        m_q   = 0;

        // 1: load, then syn_clr beats load
        load = 1'b1; d = 4'd7;
        go(1);
        check("t1_load_q", int'(q), 7);
        check("t1_load_wrap", int'(wrap), 0);
        syn_clr = 1'b1; load = 1'b1; d = 4'd9;
        go(1);
        check("t1_clr_q", int'(q), 3);
        check("t1_clr_wrap", int'(wrap), 0);
        syn_clr = 1'b0; load = 1'b0;

        // 2: up by 4 in wrap mode: 3 -> 7 -> 11 -> 3
        en = 1'b1; up = 1'b1; sat = 1'b0; step = 4'd4;
        go(1);
        check("t2_q7", int'(q), 7);
        check("t2_max7", int'(max_tick), 0);
        go(1);
        check("t2_q11", int'(q), 11);
        check("t2_wrap11", int'(wrap), 0);
        go(1);
        check("t2_q3", int'(q), 3);
        check("t2_wrap3", int'(wrap), 1);
        check("t2_max3", int'(max_tick), 0);
        en = 1'b0;
        go(1);
        check("t2_wrap_single", int'(wrap), 0);

        // 3: down by 5 in saturate mode: 12 -> 7 -> 3 -> 3
        load = 1'b1; d = 4'd12;
        go(1);
        load = 1'b0;
        check("t3_q12", int'(q), 12);
        en = 1'b1; up = 1'b0; sat = 1'b1; step = 4'd5;
        go(1);
        check("t3_q7", int'(q), 7);
        check("t3_min7", int'(min_tick), 0);
        go(1);
        check("t3_q3", int'(q), 3);
        check("t3_min3", int'(min_tick), 1);
        go(1);
        check("t3_q3_hold", int'(q), 3);
        check("t3_min3_hold", int'(min_tick), 1);
        check("t3_wrap", int'(wrap), 0);
        en = 1'b0;

        // 4: load clamp, then out-of-range recovery after lo moves
        load = 1'b1; d = 4'd15;
        go(1);
        check("t4_clamp_hi", int'(q), 12);
        d = 4'd5;
        go(1);
        check("t4_load5", int'(q), 5);
        load = 1'b0;
        lo = 4'd8; en = 1'b1; up = 1'b1; sat = 1'b0; step = 4'd1;
        go(1);
        check("t4_recover_q", int'(q), 8);
        check("t4_recover_wrap", int'(wrap), 0);
        en = 1'b0; lo = 4'd3;

        // 5: configuration error freeze, then degenerate lo == hi
        go(1);
        check("t5_start_q", int'(q), 8);
        lo = 4'd10; hi = 4'd6; en = 1'b1; up = 1'b1; sat = 1'b0; step = 4'd1;
        go(2);
        load = 1'b1; d = 4'd3;
        go(1);
        load = 1'b0; syn_clr = 1'b1;
        go(1);
        syn_clr = 1'b0;
        check("t5_frozen_q", int'(q), 8);
        check("t5_cfg_err", int'(cfg_err), 1);
        check("t5_frozen_wrap", int'(wrap), 0);
        hi = 4'd12;
        go(1);
        check("t5_resume_q", int'(q), 10);
        check("t5_cfg_clear", int'(cfg_err), 0);
        lo = 4'd9; hi = 4'd9;
        go(1);
        check("t5_pin_q", int'(q), 9);
        go(1);
        check("t5_pin_wrap1", int'(wrap), 1);
        check("t5_pin_max", int'(max_tick), 1);
        check("t5_pin_min", int'(min_tick), 1);
        go(1);
        check("t5_pin_wrap2", int'(wrap), 1);
        check("t5_pin_q2", int'(q), 9);
        en = 1'b0; lo = 4'd3; hi = 4'd12;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                lo = N'($urandom_range(0, 15));
                if ($urandom_range(0, 6) == 0) hi = N'($urandom_range(0, 15));
                else                           hi = N'($urandom_range(int'(lo), 15));
            end
            syn_clr = ($urandom_range(0, 19) == 0);
            load    = ($urandom_range(0, 9) == 0);
            d       = N'($urandom_range(0, 15));
            en      = ($urandom_range(0, 4) != 0);
            up      = $urandom_range(0, 1) == 1;
            sat     = $urandom_range(0, 1) == 1;
            step    = ($urandom_range(0, 15) == 0) ? 4'd0 : N'($urandom_range(1, 15));
            go(1);
        end
        syn_clr = 1'b0; load = 1'b0; en = 1'b0;

        // 6: asynchronous reset between edges with a wrap about to happen
        lo = 4'd3; hi = 4'd12; load = 1'b1; d = 4'd11;
        go(1);
        load = 1'b0;
        check("t6_q11", int'(q), 11);
        en = 1'b1; up = 1'b1; sat = 1'b0; step = 4'd4;
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_q", int'(q), 0);
        check("t6_async_wrap", int'(wrap), 0);
        @(negedge clk);
        check("t6_held_q", int'(q), 0);
        check("t6_held_wrap", int'(wrap), 0);
        reset = 1'b0;
        en    = 1'b0;
        m_q   = 0;
        go(1);
        check("t6_after_wrap", int'(wrap), 0);
        check("t6_after_q", int'(q), 0);

        go(2);
        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
